// File: rtl/note_spi_buffer_if.sv
// Note-capture inputs, SPI slave pins and queue status for note_spi_buffer.
interface note_spi_buffer_if #(
  parameter int AW = 4
);
  logic [7:0]  note;
  logic        new_note;
  logic [3:0]  note_dur;
  logic        sck;
  logic        cs_n;
  logic        sdo;
  logic [AW:0] fifo_cnt;
  logic        overflow;

  modport master (
    output note, new_note, note_dur, sck, cs_n,
    input  sdo, fifo_cnt, overflow
  );

  modport slave (
    input  note, new_note, note_dur, sck, cs_n,
    output sdo, fifo_cnt, overflow
  );
endinterface

// File: rtl/note_spi_buffer.sv
// Pairs each ended note's pitch with its duration, queues it, and streams one 16-bit word
// per SPI chip-select frame (mode 0, MSB first); SPI edges act 3 clk after the pins move.
module note_spi_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic              clk,
  input logic              reset,
  note_spi_buffer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    cur_pitch;
  logic [7:0]    ended_pitch;
  logic          cap_pend;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf;

  logic          sck_s1, sck_s2, sck_d;
  logic          cs_s1, cs_s2, cs_d;

  logic [1:0]    state;
  logic [15:0]   shift_reg;
  logic [4:0]    bit_cnt;

  logic          sck_fall;
  logic          cs_fall;
  logic          cs_rise;
  logic          wr_req;
  logic          pop;
  logic          full;
  logic          wr_ok;
  logic          drop;

  assign sck_fall = sck_d & ~sck_s2;
  assign cs_fall  = cs_d & ~cs_s2;
  assign cs_rise  = ~cs_d & cs_s2;

  // A capture with zero duration is the first note after reset or a too-short note.
  assign wr_req = cap_pend && (bus.note_dur != 4'd0);
  assign pop    = (state == S_LOAD) && (cnt != '0);
  assign full   = (cnt == FULL_CNT);
  assign wr_ok  = wr_req && (!full || pop);
  assign drop   = wr_req && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_pitch   <= '0;
      ended_pitch <= '0;
      cap_pend    <= 1'b0;
    end else begin
      cap_pend <= bus.new_note;
      if (bus.new_note) begin
        ended_pitch <= cur_pitch;
        cur_pitch   <= bus.note;
      end
    end
  end

  // Flops reset low so a chip select held low across reset cannot start a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      cs_s1  <= 1'b0;
      cs_s2  <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sck_s1 <= bus.sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      cs_s1  <= bus.cs_n;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {bus.note_dur, ended_pitch};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (pop) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (cs_rise) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The word carries the overflow flag as it stood before this pop clears it.
          if (cnt != '0) begin
            shift_reg <= {1'b1, ovf, 2'b00, mem[rd_ptr]};
          end else begin
            shift_reg <= 16'h0000;
          end
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sck_fall) begin
            shift_reg <= {shift_reg[14:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd15) begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_DONE;
        end
      endcase
    end
  end

  assign bus.sdo      = (state == S_SHIFT) & shift_reg[15];
  assign bus.fifo_cnt = cnt;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_note_spi_buffer.sv
// Directed stimulus with a frame scoreboard: expected SPI words are queued before each frame
// and a monitor compares every completed frame against them in order.
module tb_note_spi_buffer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  note_spi_buffer_if #(.AW(4)) bus ();

  note_spi_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int frame_no = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic send_note(input logic [7:0] p, input logic [3:0] d);
    @(negedge clk);
    bus.note     = p;
    bus.new_note = 1'b1;
    @(negedge clk);
    bus.new_note = 1'b0;
    bus.note_dur = d;
    @(negedge clk);
    bus.note_dur = 4'd0;
  endtask

  // Runs one SPI frame of nbits sck pulses; optionally injects a note so its write
  // lands on the same clock as the frame's load/pop.
  task automatic spi_frame(input int nbits, input bit inj, input logic [7:0] p, input logic [3:0] d);
    logic [15:0] w;
    w = 16'h0000;
    @(negedge clk);
    bus.cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (inj) begin
      bus.note     = p;
      bus.new_note = 1'b1;
    end
    @(negedge clk);
    bus.new_note = 1'b0;
    if (inj) bus.note_dur = d;
    @(negedge clk);
    bus.note_dur = 4'd0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      w = {w[14:0], bus.sdo};
      bus.sck = 1'b1;
      repeat (6) @(negedge clk);
      bus.sck = 1'b0;
      repeat (6) @(negedge clk);
    end
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    if (nbits == 16) obs_q.push_back(w);
  endtask

  task automatic read_frame(input logic [15:0] want);
    exp_q.push_back(want);
    spi_frame(16, 1'b0, 8'h00, 4'd0);
  endtask

  initial begin : monitor
    logic [15:0] got;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        got = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame%0d: got %h expected no frame", frame_no, got);
        end else begin
          check($sformatf("frame%0d", frame_no), {16'h0, got}, {16'h0, exp_q.pop_front()});
        end
        frame_no++;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] d;
    logic [7:0] p;
    bus.note     = 8'h00;
    bus.new_note = 1'b0;
    bus.note_dur = 4'd0;
    bus.sck      = 1'b0;
    bus.cs_n     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_sdo", bus.sdo, 0);
    check("rst_cnt", bus.fifo_cnt, 0);
    check("rst_ovf", bus.overflow, 0);

    // First note after reset carries a zero duration: nothing queued.
    send_note(8'h21, 4'd0);
    repeat (2) @(negedge clk);
    check("first_note_cnt", bus.fifo_cnt, 0);
    read_frame(16'h0000);
    check("empty_frame_cnt", bus.fifo_cnt, 0);

    send_note(8'h2A, 4'd2);
    repeat (2) @(negedge clk);
    check("pair_cnt", bus.fifo_cnt, 1);
    read_frame(16'h8221);
    check("pair_drain_cnt", bus.fifo_cnt, 0);

    // 17 valid captures into 16 slots: the last is dropped.
    for (int i = 0; i < 17; i++) begin
      send_note(8'h30 + 8'(i), 4'((i % 15) + 1));
    end
    repeat (2) @(negedge clk);
    check("ovf_cnt", bus.fifo_cnt, 16);
    check("ovf_set", bus.overflow, 1);
    read_frame(16'hC12A);
    check("ovf_clear", bus.overflow, 0);
    for (int k = 1; k < 16; k++) begin
      d = 4'((k % 15) + 1);
      p = 8'h30 + 8'(k - 1);
      read_frame({4'b1000, d, p});
    end
    check("ovf_drain_cnt", bus.fifo_cnt, 0);
    check("ovf_drain_flag", bus.overflow, 0);

    // Refill to full, then write on the very cycle a frame pops.
    for (int i = 0; i < 16; i++) begin
      send_note(8'h50 + 8'(i), 4'd3);
    end
    repeat (2) @(negedge clk);
    check("full_cnt", bus.fifo_cnt, 16);
    check("full_ovf", bus.overflow, 0);
    exp_q.push_back(16'h8340);
    spi_frame(16, 1'b1, 8'h60, 4'd5);
    check("wr_pop_cnt", bus.fifo_cnt, 16);
    check("wr_pop_ovf", bus.overflow, 0);
    read_frame(16'h8350);
    read_frame(16'h8351);
    check("pre_abort_cnt", bus.fifo_cnt, 14);

    // Aborted frame consumes 0x52 for good.
    spi_frame(5, 1'b0, 8'h00, 4'd0);
    check("abort_sdo", bus.sdo, 0);
    check("abort_cnt", bus.fifo_cnt, 13);
    read_frame(16'h8353);
    check("post_abort_cnt", bus.fifo_cnt, 12);

    // Reset in the middle of shifting 0x8354 after six bits.
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 6; b++) begin
      bus.sck = 1'b1;
      repeat (6) @(negedge clk);
      bus.sck = 1'b0;
      repeat (6) @(negedge clk);
    end
    check("mid_shift_sdo", bus.sdo, 1);
    check("mid_shift_cnt", bus.fifo_cnt, 11);
    reset = 1'b0;
    #1;
    check("mid_rst_sdo", bus.sdo, 0);
    check("mid_rst_cnt", bus.fifo_cnt, 0);
    check("mid_rst_ovf", bus.overflow, 0);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_sdo", bus.sdo, 0);
    check("post_rst_cnt", bus.fifo_cnt, 0);
    read_frame(16'h0000);

    repeat (4) @(negedge clk);
    check("frames_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
